uart_tx_arb: RTL and testbench

//   Shares one uart_tx byte FIFO port between N_REQ byte-stream requesters.

---
 rtl/uart_tx_arb_pkg.sv | 30 +++
 rtl/uart_tx_arb_if.sv | 37 +++
 rtl/uart_tx_arb_rr_pick.sv | 49 ++++
 rtl/uart_tx_arb.sv | 126 ++++++++++++
 tb/tb_uart_tx_arb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_arb_pkg
//  Purpose  : Shared types and helpers for the packet-granular UART arbiter:
//             FSM state encoding, requester-count limit and index-width
//             helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

  // Largest requester count the arbiter is built for.
  localparam int N_REQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_SEND = 2'd2
  } arb_state_t;

  // Ceiling log2; clog2(1) == 0, callers clamp to at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb_if
//  Purpose  : Bundles the requester handshake and the uart_tx FIFO port of
//             the arbiter.
//  Ports    : i_req/i_dat/i_last  requester byte streams (8 bits per requester)
//             o_ack               one-hot byte-accept pulse
//             o_busy              packet grant active
//             o_tx_dat/o_tx_push  to the uart_tx FIFO
//             i_tx_full           from the uart_tx FIFO
//  Modports : slave  - the arbiter
//             master - requesters plus uart_tx side (environment)
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_arb_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_dat;
  logic [N_REQ-1:0]   i_last;
  logic [N_REQ-1:0]   o_ack;
  logic               o_busy;
  logic [7:0]         o_tx_dat;
  logic               o_tx_push;
  logic               i_tx_full;

  modport slave (
    input  i_req, i_dat, i_last, i_tx_full,
    output o_ack, o_busy, o_tx_dat, o_tx_push
  );

  modport master (
    output i_req, i_dat, i_last, i_tx_full,
    input  o_ack, o_busy, o_tx_dat, o_tx_push
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin search: first set bit of req at or
//             after ptr, wrapping around.
//  Ports    : req  in   N_REQ   request vector
//             ptr  in   IDX_W   search start index (must be < N_REQ)
//             idx  out  IDX_W   winning index (0 when nothing requests)
//             any  out  1       at least one request is set
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;
  logic             found;

  always_comb begin
    // Rotating a doubled copy puts req[ptr] at bit 0, so a plain
    // lowest-set-bit search implements the wrap-around priority.
    rot   = N_REQ'({req, req} >> ptr);
    any   = |req;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(N_REQ)) begin
          sum = sum - (IDX_W+1)'(N_REQ);
        end
        idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Shares one uart_tx byte FIFO port between N_REQ byte-stream
//             requesters. A granted requester keeps the UART until it sends a
//             byte flagged last; packets are granted round-robin.
//  Ports    : i_clk    in  1   system clock
//             i_reset  in  1   synchronous, active-high reset
//             bus      slave modport of uart_tx_arb_if (requesters + uart_tx)
//  Config   : UART_ARB_TAG_EN - when defined, every packet is prefixed with
//             the byte TAG_BASE + requester index.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int         N_REQ    = 2,
  parameter logic [7:0] TAG_BASE = 8'h80
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_tx_arb_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 1 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("uart_tx_arb: N_REQ out of range 1..8");
  end
  if (int'(TAG_BASE) + N_REQ > 256) begin : g_bad_tag_base
    $error("uart_tx_arb: TAG_BASE + N_REQ overflows a byte");
  end

  arb_state_t       state, state_nx;
  logic [IDX_W-1:0] gnt, gnt_nx;
  logic [IDX_W-1:0] rr_ptr, rr_nx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] ack;
  logic             tx_push, push_nx;
  logic [7:0]       tx_dat, dat_nx;
  logic             gnt_req, gnt_last;
  logic [7:0]       gnt_dat;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (bus.i_req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign gnt_req  = bus.i_req[gnt];
  assign gnt_last = bus.i_last[gnt];
  assign gnt_dat  = bus.i_dat[{gnt, 3'b000} +: 8];

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr_ptr;
    ack      = '0;
    push_nx  = 1'b0;
    dat_nx   = tx_dat;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nx   = pick_idx;
`ifdef UART_ARB_TAG_EN
          state_nx = ST_TAG;
`else
          state_nx = ST_SEND;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        if (!bus.i_tx_full && !tx_push) begin
          push_nx  = 1'b1;
          dat_nx   = TAG_BASE + 8'(gnt);
          state_nx = ST_SEND;
        end
      end
`endif
      ST_SEND: begin
        // Blocking on tx_push spaces pushes two cycles apart, which hides
        // the one-cycle lag of the FIFO full flag.
        if (gnt_req && !bus.i_tx_full && !tx_push) begin
          ack     = N_REQ'(1) << gnt;
          push_nx = 1'b1;
          dat_nx  = gnt_dat;
          if (gnt_last) begin
            state_nx = ST_IDLE;
            rr_nx    = (gnt == IDX_W'(N_REQ-1)) ? '0 : gnt + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      rr_ptr  <= '0;
      tx_push <= 1'b0;
      tx_dat  <= 8'h00;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      rr_ptr  <= rr_nx;
      tx_push <= push_nx;
      tx_dat  <= dat_nx;
    end
  end

  assign bus.o_ack     = ack;
  assign bus.o_busy    = (state != ST_IDLE);
  assign bus.o_tx_push = tx_push;
  assign bus.o_tx_dat  = tx_dat;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Self-checking bench for uart_tx_arb with N_REQ=2, a 2-deep
//             uart_tx FIFO model draining one byte per 160-clock frame, and a
//             packet-level round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int         N      = 2;
  localparam logic [7:0] TB_TAG = 8'h80;
  localparam int         FRAME  = 160;  // 16 clocks/bit * 10 bits
  localparam int         DEPTH  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N)) bus ();

  uart_tx_arb #(
    .N_REQ    (N),
    .TAG_BASE (TB_TAG)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester byte queues (driven) and reference-model copies.
  logic [7:0] q_dat  [N][$];
  bit         q_last [N][$];
  logic [7:0] m_dat  [N][$];
  bit         m_last [N][$];
  bit         stall  [N];
  int         ack_cnt[N];

  logic [7:0] exp_line[$];
  logic [7:0] got_line[$];
  logic [7:0] fifo[$];
  int         frame_timer  = 0;
  int         last_push_cyc = -10;
  int         last_acc_cyc  = -10;
  int         model_rr      = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: requester drivers, uart_tx FIFO model, protocol checks.
  initial begin : env
    logic [N-1:0]   s_ack, s_req, v_req, v_last;
    logic [8*N-1:0] v_dat;
    logic           s_push, s_busy;
    logic [7:0]     s_dat;
    bus.i_req = '0; bus.i_dat = '0; bus.i_last = '0; bus.i_tx_full = 1'b0;
    for (int k = 0; k < N; k++) begin stall[k] = 1'b0; ack_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      s_ack = bus.o_ack; s_req = bus.i_req; s_push = bus.o_tx_push;
      s_dat = bus.o_tx_dat; s_busy = bus.o_busy;
      if (s_ack != '0) begin
        chk("ack_onehot_on_req", int'(($countones(s_ack) == 1) && ((s_ack & ~s_req) == '0)), 1);
        chk("busy_on_accept", int'(s_busy), 1);
        for (int k = 0; k < N; k++) begin
          if (s_ack[k]) begin
            ack_cnt[k]++;
            if (q_last[k].size() > 0 && q_last[k][0]) last_acc_cyc = cyc;
          end
        end
      end
      if (s_push) begin
        chk("no_push_when_full", int'(bus.i_tx_full), 0);
        chk("push_spacing", int'((cyc - last_push_cyc) >= 2), 1);
        last_push_cyc = cyc;
      end
      if (cyc == last_acc_cyc + 1) begin
        chk("push_after_last", int'(s_push), 1);
        chk("idle_after_last", int'(s_busy), 0);
      end
      @(posedge clk); #1;
      // uart_tx model: start a new frame when the shifter is free.
      if (frame_timer > 0) frame_timer--;
      if (frame_timer == 0 && fifo.size() > 0) begin
        got_line.push_back(fifo.pop_front());
        frame_timer = FRAME;
      end
      if (s_push) fifo.push_back(s_dat);
      bus.i_tx_full = (fifo.size() >= DEPTH);
      // Requesters: consume acked byte, present the next one.
      for (int k = 0; k < N; k++) begin
        if (s_ack[k] && q_dat[k].size() > 0) begin
          void'(q_dat[k].pop_front());
          void'(q_last[k].pop_front());
        end
        v_req[k]         = (q_dat[k].size() > 0) && !stall[k];
        v_dat[8*k +: 8]  = (q_dat[k].size() > 0) ? q_dat[k][0] : 8'h00;
        v_last[k]        = (q_last[k].size() > 0) ? q_last[k][0] : 1'b0;
      end
      bus.i_req = v_req; bus.i_dat = v_dat; bus.i_last = v_last;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic load_pkt(input int k, input int len, input logic [7:0] first,
                          input logic [7:0] stp, input bit rnd, input bit to_model);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : first + 8'(i) * stp;
      q_dat[k].push_back(b);
      q_last[k].push_back(i == len - 1);
      if (to_model) begin
        m_dat[k].push_back(b);
        m_last[k].push_back(i == len - 1);
      end
    end
  endtask

  // Packet-level round robin: whole packets, next search starts after the
  // requester just served.
  task automatic model_run();
    int  found;
    bit  l;
    forever begin
      found = -1;
      for (int i = 0; i < N; i++) begin
        if (found < 0 && m_dat[(model_rr + i) % N].size() > 0) found = (model_rr + i) % N;
      end
      if (found < 0) break;
`ifdef UART_ARB_TAG_EN
      exp_line.push_back(TB_TAG + 8'(found));
`endif
      do begin
        exp_line.push_back(m_dat[found].pop_front());
        l = m_last[found].pop_front();
      end while (!l);
      model_rr = (found + 1) % N;
    end
  endtask

  task automatic drain(input string tag);
    int t, budget;
    bit pend;
    t = 0;
    budget = exp_line.size() * (FRAME + 40) + 600;
    forever begin
      pend = 1'b0;
      for (int k = 0; k < N; k++) if (q_dat[k].size() > 0) pend = 1'b1;
      if (!(pend || bus.o_busy || fifo.size() > 0 || got_line.size() < exp_line.size())) break;
      if (t >= budget) break;
      step();
      t++;
    end
    chk({tag, "_timeout"}, int'(t < budget), 1);
    chk({tag, "_len"}, got_line.size(), exp_line.size());
    for (int i = 0; i < exp_line.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got_line.size()) ? int'(got_line[i]) : -1, int'(exp_line[i]));
    end
    chk({tag, "_rr"}, int'(dut.rr_ptr), model_rr);
    exp_line.delete();
    got_line.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    model_rr = 0;
  endtask

  initial begin : stim
    int a0, a1, t;
    repeat (4) step();
    // Reset state
    chk("rst_ack", int'(bus.o_ack), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_push", int'(bus.o_tx_push), 0);
    chk("rst_txdat", int'(bus.o_tx_dat), 0);
    chk("rst_rr", int'(dut.rr_ptr), 0);
    reset = 1'b0;
    model_rr = 0;
    step();

    // 1: single requester, 3-byte packet
    a0 = ack_cnt[0];
    load_pkt(0, 3, 8'h11, 8'h11, 1'b0, 1'b1);
    model_run();
    drain("t1");
    chk("t1_ack0_count", ack_cnt[0] - a0, 3);

    // 2: contention straight from reset
    do_reset();
    load_pkt(0, 2, 8'hA0, 8'h01, 1'b0, 1'b1);
    load_pkt(1, 2, 8'hB0, 8'h01, 1'b0, 1'b1);
    model_run();
    drain("t2");

    // 3: back-pressure on a long packet
    load_pkt(0, 6, 8'h31, 8'h01, 1'b0, 1'b1);
    model_run();
    drain("t3");

    // 4: mid-packet stall of req0 while req1 waits
    load_pkt(0, 3, 8'h41, 8'h01, 1'b0, 1'b0);
`ifdef UART_ARB_TAG_EN
    exp_line.push_back(TB_TAG + 8'd0);
`endif
    exp_line.push_back(8'h41); exp_line.push_back(8'h42); exp_line.push_back(8'h43);
    a0 = ack_cnt[0];
    t = 0;
    while (ack_cnt[0] == a0 && t < 1000) begin step(); t++; end
    chk("t4_first_ack_timeout", int'(t < 1000), 1);
    stall[0] = 1'b1;
    load_pkt(1, 2, 8'h51, 8'h01, 1'b0, 1'b0);
    a1 = ack_cnt[1];
    repeat (50) step();
    chk("t4_req1_blocked", ack_cnt[1] - a1, 0);
    chk("t4_busy_locked", int'(bus.o_busy), 1);
    stall[0] = 1'b0;
`ifdef UART_ARB_TAG_EN
    exp_line.push_back(TB_TAG + 8'd1);
`endif
    exp_line.push_back(8'h51); exp_line.push_back(8'h52);
    model_rr = (1 + 1) % N;
    drain("t4");

    // 5: reset on the second accept cycle of req1
    load_pkt(1, 4, 8'h71, 8'h01, 1'b0, 1'b0);
    a1 = ack_cnt[1];
    t = 0;
    while (!(bus.o_ack[1] && ack_cnt[1] == a1 + 2) && t < 2000) begin step(); t++; end
    chk("t5_accept_timeout", int'(t < 2000), 1);
    reset = 1'b1;
    q_dat[1].delete();
    q_last[1].delete();
`ifdef UART_ARB_TAG_EN
    exp_line.push_back(TB_TAG + 8'd1);
`endif
    exp_line.push_back(8'h71);
    step();
    chk("t5_push_after_rst", int'(bus.o_tx_push), 0);
    chk("t5_busy_after_rst", int'(bus.o_busy), 0);
    chk("t5_rr_after_rst", int'(dut.rr_ptr), 0);
    reset = 1'b0;
    model_rr = 0;
    load_pkt(0, 2, 8'h91, 8'h01, 1'b0, 1'b1);
    model_run();
    drain("t5");

    // 6: single-byte packet from req1 (tag prefix when enabled)
    a1 = ack_cnt[1];
    load_pkt(1, 1, 8'h55, 8'h00, 1'b0, 1'b1);
    model_run();
    drain("t6");
    chk("t6_ack1_count", ack_cnt[1] - a1, 1);

    // Randomized packet mixes
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          load_pkt(k, $urandom_range(1, 4), 8'h00, 8'h00, 1'b1, 1'b1);
        end
      end
      model_run();
      drain($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
